mux32x2_arbiter: RTL and testbench
==================================

Name: mux32x2_arbiter

Overview:
- Controller for the 32-bit 2:1 multiplexer (mux32x2): shares it between two requesters with valid/ready handshakes.
- Drives the mux select, captures the mux output into a one-entry output register, and presents it downstream with valid/ready.
- Round-robin fairness between requesters; optional burst lock keeps multi-beat transfers contiguous.
- Sits between producer pipelines in the NN simulator datapath and a shared 32-bit consumer.

Parameters:
- WIDTH, 32, data width of the mux output and the output register.
- INIT_PRIO, 0, requester preferred first after reset (0 or 1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in0_valid  input  1  requester 0 has a beat on mux input 0.
- in0_last  input  1  requester 0 beat is final beat of a burst (used only with ARB_BURST_LOCK_EN).
- in0_ready  output  1  requester 0 beat accepted this cycle.
- in1_valid  input  1  requester 1 has a beat on mux input 1.
- in1_last  input  1  requester 1 final-beat flag (used only with ARB_BURST_LOCK_EN).
- in1_ready  output  1  requester 1 beat accepted this cycle.
- mux_sel  output  1  select to mux32x2 (0 = in0, 1 = in1).
- mux_out  input  WIDTH  mux32x2 output, fed back for capture.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  captured beat.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (async, any time including mid-transfer): out_valid=0, out_data=0, prio=INIT_PRIO, state=ARB. in0_ready and in1_ready are forced 0 while rst is high. A beat held at reset is dropped.
- space = !out_valid || out_ready. A full output register that is drained this cycle can accept a new beat in the same cycle.
- Grant choice (combinational), state ARB:
  - only in0_valid -> 0; only in1_valid -> 1.
  - both valid -> prio.
  - neither valid -> mux_sel=prio.
- inN_ready = space && inN_valid && (grant==N). At most one ready is high per cycle. Ready never rises without the matching valid.
- Accept (inN_valid && inN_ready):
  - out_data <= mux_out; out_valid <= 1.
  - prio <= ~N, so the other requester wins the next tie.
- Latency: beat accepted at edge k appears on out_data/out_valid after edge k. Throughput is 1 beat/cycle when out_ready is held 1.
- Drain: out_valid && out_ready && no accept -> out_valid <= 0. out_data holds its last value.
- Backpressure: when out_valid && !out_ready, both readys are 0 and out_data is stable.
- mux_sel is combinational from the grant. It changes only with the valids, prio or state, never mid-cycle after an accept decision.
- No beat is ever duplicated or lost. The data width is WIDTH end to end with no arithmetic.

Optional Feature:
- Macro: ARB_BURST_LOCK_EN.
- Defined:
  - Adds FSM states ARB, LOCK0, LOCK1.
  - ARB -> LOCKn on accept from n with inN_last=0.
  - In LOCKn, grant is forced to n; the other requester's ready stays 0 even if inN_valid drops.
  - LOCKn -> ARB on accept from n with inN_last=1.
  - prio updates only on a last-beat accept.
  - Reset returns to ARB.
- Undefined:
  - No lock states; every beat is arbitrated independently.
  - in0_last and in1_last are ignored but the ports remain present.

Test Plan:
- Reset with both valids high, INIT_PRIO=0 -> both readys 0 and out_valid 0. After release, the first accept is in0 (mux_out=FFFFFFFF) and out_data=FFFFFFFF one edge later.
- Both valid continuously, in0 data 01234567, in1 data ABCDEF00, out_ready=1 -> out_data alternates 01234567, ABCDEF00, ... each cycle and mux_sel toggles.
- Only in1 valid (BBBB0000) with prio=0 -> in1 granted immediately, out_data=BBBB0000 and prio becomes 0.
- out_ready=0 for 3 cycles while full -> readys 0 and out_data stable. Raise out_ready -> drain and accept occur in the same cycle with no gap.
- Assert rst mid-stream while out_valid=1 -> out_valid=0 and out_data=0 asynchronously; prio returns to INIT_PRIO.
- ARB_BURST_LOCK_EN: in0 sends 3 beats (last on the 3rd) while in1 valid -> in1_ready stays 0 until the in0 last beat is accepted, and in1 wins the next cycle.

Source files
------------

// File: rtl/mux32x2_arbiter_if.sv
// Handshake bundle between the mux32x2 arbiter, its two requesters, the shared
// mux and the downstream consumer. master = arbiter side, slave = environment side.
interface mux32x2_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             in0_valid;
  logic             in0_last;
  logic             in0_ready;
  logic             in1_valid;
  logic             in1_last;
  logic             in1_ready;
  logic             mux_sel;
  logic [WIDTH-1:0] mux_out;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    input  in0_valid, in0_last, in1_valid, in1_last, mux_out, out_ready,
    output in0_ready, in1_ready, mux_sel, out_valid, out_data
  );

  modport slave (
    output in0_valid, in0_last, in1_valid, in1_last, mux_out, out_ready,
    input  in0_ready, in1_ready, mux_sel, out_valid, out_data
  );
endinterface

// File: rtl/mux32x2_arbiter.sv
// Round-robin arbiter sharing a 32-bit 2:1 mux between two requesters, with a
// one-entry output register. Define ARB_BURST_LOCK_EN to keep bursts contiguous.
module mux32x2_arbiter #(
  parameter int WIDTH     = 32,
  parameter bit INIT_PRIO = 1'b0
) (
  input logic                clk,
  input logic                rst,
  mux32x2_arbiter_if.master  bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             prio_q,      prio_d;
  logic             grant;
  logic             space;
  logic             acc0, acc1, acc;
  logic             acc_last;

`ifdef ARB_BURST_LOCK_EN
  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;
  state_t state_q, state_d;
`endif

  assign space = !out_valid_q || bus.out_ready;

  always_comb begin
    grant = prio_q;
    if (bus.in0_valid && !bus.in1_valid)      grant = 1'b0;
    else if (bus.in1_valid && !bus.in0_valid) grant = 1'b1;
`ifdef ARB_BURST_LOCK_EN
    // A locked burst owns the mux regardless of what either requester presents.
    if (state_q == LOCK0)      grant = 1'b0;
    else if (state_q == LOCK1) grant = 1'b1;
`endif
  end

  assign bus.in0_ready = !rst && space && bus.in0_valid && (grant == 1'b0);
  assign bus.in1_ready = !rst && space && bus.in1_valid && (grant == 1'b1);
  assign bus.mux_sel   = grant;

  assign acc0     = bus.in0_valid && bus.in0_ready;
  assign acc1     = bus.in1_valid && bus.in1_ready;
  assign acc      = acc0 || acc1;
`ifdef ARB_BURST_LOCK_EN
  assign acc_last = acc1 ? bus.in1_last : bus.in0_last;
`else
  assign acc_last = 1'b1;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    prio_d      = prio_q;
    if (acc) begin
      out_data_d  = bus.mux_out;
      out_valid_d = 1'b1;
      if (acc_last) prio_d = ~grant;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      prio_q      <= INIT_PRIO;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      prio_q      <= prio_d;
    end
  end

`ifdef ARB_BURST_LOCK_EN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (acc && !acc_last) state_d = acc1 ? LOCK1 : LOCK0;
      LOCK0,
      LOCK1:   if (acc && acc_last)  state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARB;
    else     state_q <= state_d;
  end
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_mux32x2_arbiter.sv
// Bench for mux32x2_arbiter: directed vector table, reset/lock sequences, and
// randomized traffic against a behavioural model of the arbitration rules.
module tb_mux32x2_arbiter;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  logic [WIDTH-1:0] d0, d1;
  int n_cmp  = 0;
  int n_fail = 0;

  mux32x2_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux32x2_arbiter #(.WIDTH(WIDTH), .INIT_PRIO(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mux_out = bus.mux_sel ? d1 : d0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v0, v1, l0, l1, ordy;
    logic [31:0] d0, d1;
    logic        r0, r1, sel, ov;
    logic [31:0] od;
  } vec_t;

  vec_t tbl [12];
`ifdef ARB_BURST_LOCK_EN
  vec_t ltbl [5];
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, v1, l0, l1, ordy, input logic [31:0] a, b);
    bus.in0_valid = v0;
    bus.in1_valid = v1;
    bus.in0_last  = l0;
    bus.in1_last  = l1;
    bus.out_ready = ordy;
    d0 = a;
    d1 = b;
  endtask

  task automatic run_row(input string tag, input vec_t v);
    drive(v.v0, v.v1, v.l0, v.l1, v.ordy, v.d0, v.d1);
    #1;
    chk({tag, ".in0_ready"}, {31'd0, bus.in0_ready}, {31'd0, v.r0});
    chk({tag, ".in1_ready"}, {31'd0, bus.in1_ready}, {31'd0, v.r1});
    chk({tag, ".mux_sel"},   {31'd0, bus.mux_sel},   {31'd0, v.sel});
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v.ov});
    chk({tag, ".out_data"},  bus.out_data, v.od);
  endtask

  // Behavioural model: output slot occupancy, stored word, tie-break owner, burst owner.
  bit          m_full;
  logic [31:0] m_data;
  bit          m_prio;
  int          m_lock;

  function automatic bit m_grant(input bit v0, input bit v1);
    if (m_lock >= 0)  return m_lock[0];
    if (v0 && !v1)    return 1'b0;
    if (v1 && !v0)    return 1'b1;
    return m_prio;
  endfunction

  initial begin
    // Directed table, all beats flagged last so both builds behave identically.
    tbl[0]  = '{1,1,1,1,1, 32'hFFFFFFFF, 32'hABCDEF00, 1,0,0,1, 32'hFFFFFFFF};
    tbl[1]  = '{1,1,1,1,1, 32'h01234567, 32'hABCDEF00, 0,1,1,1, 32'hABCDEF00};
    tbl[2]  = '{1,1,1,1,1, 32'h01234567, 32'hABCDEF00, 1,0,0,1, 32'h01234567};
    tbl[3]  = '{1,1,1,1,1, 32'h01234567, 32'hABCDEF00, 0,1,1,1, 32'hABCDEF00};
    tbl[4]  = '{0,1,1,1,1, 32'h00000000, 32'hBBBB0000, 0,1,1,1, 32'hBBBB0000};
    tbl[5]  = '{1,1,1,1,0, 32'h11111111, 32'hCCCCCCCC, 0,0,0,1, 32'hBBBB0000};
    tbl[6]  = '{1,1,1,1,0, 32'h11111111, 32'hCCCCCCCC, 0,0,0,1, 32'hBBBB0000};
    tbl[7]  = '{1,1,1,1,0, 32'h11111111, 32'hCCCCCCCC, 0,0,0,1, 32'hBBBB0000};
    tbl[8]  = '{1,1,1,1,1, 32'h11111111, 32'hCCCCCCCC, 1,0,0,1, 32'h11111111};
    tbl[9]  = '{0,0,1,1,1, 32'h11111111, 32'hCCCCCCCC, 0,0,1,0, 32'h11111111};
    tbl[10] = '{0,0,1,1,0, 32'h11111111, 32'hCCCCCCCC, 0,0,1,0, 32'h11111111};
    tbl[11] = '{1,0,1,1,0, 32'h22222222, 32'hCCCCCCCC, 1,0,0,1, 32'h22222222};
`ifdef ARB_BURST_LOCK_EN
    ltbl[0] = '{1,1,0,1,1, 32'hA0000001, 32'hB0000001, 1,0,0,1, 32'hA0000001};
    ltbl[1] = '{0,1,0,1,1, 32'hA0000001, 32'hB0000001, 0,0,0,0, 32'hA0000001};
    ltbl[2] = '{1,1,0,1,1, 32'hA0000002, 32'hB0000001, 1,0,0,1, 32'hA0000002};
    ltbl[3] = '{1,1,1,1,1, 32'hA0000003, 32'hB0000001, 1,0,0,1, 32'hA0000003};
    ltbl[4] = '{1,1,1,1,1, 32'hA0000004, 32'hB0000001, 0,1,1,1, 32'hB0000001};
`endif

    // Reset held with both requesters pending.
    rst = 1'b1;
    drive(1, 1, 1, 1, 1, 32'hFFFFFFFF, 32'hABCDEF00);
    #3;
    chk("rst.in0_ready", {31'd0, bus.in0_ready}, 32'd0);
    chk("rst.in1_ready", {31'd0, bus.in1_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.out_data",  bus.out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_row($sformatf("tbl%0d", i), tbl[i]);

    // Asynchronous reset mid-stream while the output register is full.
    drive(1, 1, 1, 1, 0, 32'h33333333, 32'h44444444);
    #2;
    rst = 1'b1;
    #1;
    chk("amid.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("amid.out_data",  bus.out_data, 32'd0);
    chk("amid.in0_ready", {31'd0, bus.in0_ready}, 32'd0);
    chk("amid.in1_ready", {31'd0, bus.in1_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_row("post_rst", '{1,1,1,1,1, 32'hFFFFFFFF, 32'hABCDEF00, 1,0,0,1, 32'hFFFFFFFF});

`ifdef ARB_BURST_LOCK_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run_row($sformatf("lock%0d", i), ltbl[i]);
`endif

    // Randomized traffic against the model, starting from a fresh reset.
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_full = 0; m_data = '0; m_prio = 1'b0; m_lock = -1;
    for (int c = 0; c < 3000; c++) begin
      bit v0, v1, l0, l1, ordy, g, e0, e1, sp;
      v0   = ($urandom_range(0, 3) != 0);
      v1   = ($urandom_range(0, 3) != 0);
      l0   = ($urandom_range(0, 2) == 0);
      l1   = ($urandom_range(0, 2) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      drive(v0, v1, l0, l1, ordy, $urandom, $urandom);
      #1;
      sp = !m_full || ordy;
      g  = m_grant(v0, v1);
      e0 = sp && v0 && !g;
      e1 = sp && v1 && g;
      chk("rnd.in0_ready", {31'd0, bus.in0_ready}, {31'd0, e0});
      chk("rnd.in1_ready", {31'd0, bus.in1_ready}, {31'd0, e1});
      chk("rnd.mux_sel",   {31'd0, bus.mux_sel},   {31'd0, g});
      if (e0 || e1) begin
        bit last;
        m_data = e1 ? d1 : d0;
        m_full = 1;
`ifdef ARB_BURST_LOCK_EN
        last = e1 ? l1 : l0;
        m_lock = last ? -1 : (e1 ? 1 : 0);
`else
        last = 1'b1;
`endif
        if (last) m_prio = !e1;
      end else if (ordy) begin
        m_full = 0;
      end
      @(posedge clk);
      #1;
      chk("rnd.out_valid", {31'd0, bus.out_valid}, {31'd0, m_full});
      chk("rnd.out_data",  bus.out_data, m_data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
